// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_SLT = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_if.sv
// Request/result bundle between the control unit and the sequential ALU.
interface alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             zero;
  logic             cout;
  logic             overflow;

  modport master (
    output start, op, A, B,
    input  ready, done, Result, zero, cout, overflow
  );

  modport slave (
    input  start, op, A, B,
    output ready, done, Result, zero, cout, overflow
  );
endinterface

// File: rtl/alu_addsub.sv
// Combinational WIDTH+1-bit adder shared by ADD, SUB and SLT.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bnegate,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full_sum;

  assign b_eff    = Bnegate ? ~B : B;
  assign full_sum = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Bnegate};
  assign sum      = full_sum[WIDTH-1:0];
  assign cout     = full_sum[WIDTH];
  // Same-sign operands producing an opposite-sign sum.
  assign overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith, shifts iterated one bit per cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic  clk,
  input logic  reset,
  alu_if.slave bus
);
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [SHW-1:0]   count_reg, count_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   shamt;
  logic             bnegate;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] sll_step;
  logic [WIDTH-1:0] sra_step;
  logic [WIDTH-1:0] sh_step;

  assign accept   = bus.start & (state_reg != S_SHIFT);
  assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRA);
  assign shamt    = bus.B[SHW-1:0];
  assign bnegate  = (bus.op == OP_SUB) || (bus.op == OP_SLT);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .A        (bus.A),
    .B        (bus.B),
    .Bnegate  (bnegate),
    .sum      (as_sum),
    .cout     (as_cout),
    .overflow (as_ovf)
  );

  // One-bit shift network: SLL fills zero, SRA replicates the sign bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == 0) begin : g_lsb
      assign sll_step[gi] = 1'b0;
    end else begin : g_mid
      assign sll_step[gi] = sh_reg[gi-1];
    end
    if (gi == WIDTH - 1) begin : g_msb
      assign sra_step[gi] = sh_reg[gi];
    end else begin : g_low
      assign sra_step[gi] = sh_reg[gi+1];
    end
  end

  assign sh_step = (op_reg == OP_SLL) ? sll_step : sra_step;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_AND: alu_res = bus.A & bus.B;
      OP_OR:  alu_res = bus.A | bus.B;
      OP_XOR: alu_res = bus.A ^ bus.B;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      OP_ADD, OP_SUB: begin
        alu_res = as_sum;
        alu_c   = as_cout;
        alu_v   = as_ovf;
      end
      default: alu_res = bus.A;  // zero-amount shift
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    sh_next     = sh_reg;
    count_next  = count_reg;
    op_next     = op_reg;
    result_next = result_reg;
    cout_next   = cout_reg;
    ovf_next    = ovf_reg;
    case (state_reg)
      S_SHIFT: begin
        sh_next    = sh_step;
        count_next = count_reg - SHW'(1);
        if (count_reg == SHW'(1)) begin
          state_next  = S_DONE;
          result_next = sh_step;
          cout_next   = 1'b0;
          ovf_next    = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          op_next    = bus.op;
          count_next = shamt;
          sh_next    = bus.A;
          if (is_shift && (shamt != '0)) begin
            state_next = S_SHIFT;
          end else begin
            state_next  = S_DONE;
            result_next = alu_res;
            cout_next   = alu_c;
            ovf_next    = alu_v;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      sh_reg     <= '0;
      count_reg  <= '0;
      op_reg     <= OP_AND;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sh_reg     <= sh_next;
      count_reg  <= count_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign bus.ready    = (state_reg != S_SHIFT);
  assign bus.done     = (state_reg == S_DONE);
  assign bus.Result   = result_reg;
  assign bus.zero     = (result_reg == '0);
  assign bus.cout     = cout_reg;
  assign bus.overflow = ovf_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] last_res;

  alu_if #(.WIDTH(16)) intf ();

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the operands.
  task automatic model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic c, output logic v,
                       output int lat, output int rlow);
    int sa, sb, r, sh;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    c = 1'b0;
    v = 1'b0;
    res = 16'h0;
    lat = 1;
    rlow = 0;
    case (o)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SLT: res = (sa < sb) ? 16'h1 : 16'h0;
      OP_ADD: begin
        res = a + b;
        c = (int'(a) + int'(b)) > 65535;
        r = sa + sb;
        v = (r > 32767) || (r < -32768);
      end
      OP_SUB: begin
        res = a - b;
        c = (a >= b);
        r = sa - sb;
        v = (r > 32767) || (r < -32768);
      end
      OP_SLL: res = a << sh;
      default: res = 16'($signed(a) >>> sh);
    endcase
    if ((o == OP_SLL || o == OP_SRA) && sh != 0) begin
      lat = sh + 1;
      rlow = sh;
    end
  endtask

  // Called at a negedge; issues one op and waits for done. inj>0 drives an
  // ignored ADD start at that cycle while the block is busy.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input int inj);
    logic [15:0] er;
    logic ec, ev;
    int elat, erlow, lat, rlow;
    model(o, a, b, er, ec, ev, elat, erlow);
    intf.start = 1'b1;
    intf.op = o;
    intf.A = a;
    intf.B = b;
    lat = 0;
    rlow = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!intf.ready) rlow++;
      if (lat == inj && !intf.done) begin
        intf.start = 1'b1;
        intf.op = OP_ADD;
        intf.A = 16'h1111;
        intf.B = 16'h2222;
      end else begin
        intf.start = 1'b0;
      end
    end while (!intf.done && lat < 40);
    chk("latency", lat, elat);
    chk("ready_low", rlow, erlow);
    chk("result", intf.Result, er);
    chk("zero", intf.zero, (er == 16'h0));
    chk("cout", intf.cout, ec);
    chk("overflow", intf.overflow, ev);
    last_res = er;
    $display("op=%0d A=%h B=%h Result=%h exp=%h lat=%0d", o, a, b, intf.Result, er, lat);
  endtask

  task automatic idle_cycle();
    intf.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", intf.done, 1'b0);
    chk("held_result", intf.Result, last_res);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    intf.start = 1'b0;
    intf.op = OP_AND;
    intf.A = 16'h0;
    intf.B = 16'h0;
    last_res = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", intf.ready, 1'b1);
    chk("rst_done", intf.done, 1'b0);
    chk("rst_result", intf.Result, 16'h0);
    chk("rst_zero", intf.zero, 1'b1);
    chk("rst_cout", intf.cout, 1'b0);
    chk("rst_ovf", intf.overflow, 1'b0);
    reset = 1'b0;

    run_op(OP_ADD, 16'h7FFF, 16'h0001, 0);
    idle_cycle();
    run_op(OP_SUB, 16'h0005, 16'h0005, 0);
    run_op(OP_ADD, 16'h0003, 16'h0004, 0);
    idle_cycle();
    run_op(OP_SLT, 16'hFFFF, 16'h0001, 0);
    run_op(OP_SLT, 16'h0001, 16'hFFFF, 0);
    run_op(OP_SLT, 16'h8000, 16'h7FFF, 0);
    idle_cycle();
    run_op(OP_SLL, 16'h0001, 16'h0004, 2);
    idle_cycle();
    run_op(OP_SRA, 16'h8000, 16'h000F, 0);
    run_op(OP_SRA, 16'h1234, 16'h0000, 0);
    idle_cycle();

    // Reset two cycles into a long shift discards it.
    intf.start = 1'b1;
    intf.op = OP_SLL;
    intf.A = 16'h0001;
    intf.B = 16'h000A;
    @(posedge clk);
    @(negedge clk);
    intf.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", intf.ready, 1'b1);
    chk("mid_rst_done", intf.done, 1'b0);
    chk("mid_rst_result", intf.Result, 16'h0);
    chk("mid_rst_zero", intf.zero, 1'b1);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (intf.done) seen++;
    end
    chk("no_done_after_rst", seen, 0);

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    intf.start = 1'b1;
    intf.op = OP_ADD;
    intf.A = 16'h0001;
    intf.B = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    intf.start = 1'b0;
    chk("rst_start_done", intf.done, 1'b0);
    chk("rst_start_result", intf.Result, 16'h0);
    last_res = 16'h0;
    idle_cycle();

    for (int n = 0; n < 150; n++) begin
      logic [2:0] o;
      logic [15:0] a, b;
      int inj;
      o = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = {a[15], 15'h0};
      if ($urandom_range(0, 3) == 0) b = a;
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_op(o, a, b, inj);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
